// File: rtl/instruction_memory_sync_if.sv
// Bus bundle for instruction_memory_sync: IF-stage fetch port plus the
// streaming program-load port. The master is the CPU/loader side and the
// slave is the memory.
interface instruction_memory_sync_if #(
  parameter int DATA_WIDTH = 32
);
  // Fetch side
  logic                  FetchEn;
  logic                  Stall;
  logic [31:0]           Address;
  logic [DATA_WIDTH-1:0] Instruction;
  logic                  InstValid;
  logic                  AddrFault;
  // Load side
  logic                  LoadStart;
  logic                  LoadValid;
  logic [DATA_WIDTH-1:0] LoadData;
  logic                  LoadLast;
  logic                  LoadReady;
  logic                  Busy;

  modport master (
    output FetchEn, Stall, Address, LoadStart, LoadValid, LoadData, LoadLast,
    input  Instruction, InstValid, AddrFault, LoadReady, Busy
  );

  modport slave (
    input  FetchEn, Stall, Address, LoadStart, LoadValid, LoadData, LoadLast,
    output Instruction, InstValid, AddrFault, LoadReady, Busy
  );
endinterface

// File: rtl/instruction_memory_sync.sv
// Loadable instruction memory with a registered, stall-holding read port.
// An IDLE/LOAD/RUN state machine sequences program loading and fetching;
// a fetch is only honoured after a load has completed.
// Optional feature: define IMEM_BOUNDS_CHECK_EN to flag fetches whose upper
// address bits are non-zero (AddrFault) instead of wrapping the index.
module instruction_memory_sync #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic                     clk,
  input logic                     reset,
  instruction_memory_sync_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_next;
  logic                  accept;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] instr;
  logic                  inst_valid;

  logic [ADDR_WIDTH-1:0] word_index;
  logic                  addr_oob;
  logic                  fetch_slot;

  assign word_index = bus.Address[ADDR_WIDTH+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
  logic addr_fault;
  logic unused_addr;

  assign addr_oob    = |bus.Address[31:ADDR_WIDTH+2];
  assign unused_addr = ^bus.Address[1:0];
`else
  logic unused_addr;

  // Upper address bits are don't-care: the index simply wraps modulo DEPTH.
  assign addr_oob    = 1'b0;
  assign unused_addr = ^{bus.Address[31:ADDR_WIDTH+2], bus.Address[1:0]};
`endif

  // The output register may only change in RUN, and LoadStart pre-empts a fetch.
  assign fetch_slot = (state == RUN) && !bus.LoadStart;

  // State and load pointer register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next-state logic: load sequencing, restart and end-of-array exit.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.LoadStart) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      LOAD: begin
        if (bus.LoadStart) begin
          // Restart wins over any word offered in the same cycle.
          ptr_next = '0;
        end else if (bus.LoadValid) begin
          accept   = 1'b1;
          ptr_next = ptr + 1'b1;
          // Writing the top word ends the load so word 0 is never overwritten.
          if (bus.LoadLast || (&ptr)) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (bus.LoadStart) begin
          state_next = LOAD;
          ptr_next   = '0;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Memory write port; the array is deliberately not touched by reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[ptr] <= bus.LoadData;
    end
  end

  // Registered fetch: new word, NOP, or hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr      <= '0;
      inst_valid <= 1'b0;
    end else if (fetch_slot) begin
      if (!bus.Stall) begin
        if (bus.FetchEn) begin
          instr      <= addr_oob ? '0 : mem[word_index];
          inst_valid <= 1'b1;
        end else begin
          instr      <= '0;
          inst_valid <= 1'b0;
        end
      end
    end else begin
      instr      <= '0;
      inst_valid <= 1'b0;
    end
  end

`ifdef IMEM_BOUNDS_CHECK_EN
  // Out-of-range flag follows the same fetch/hold timing as Instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_fault <= 1'b0;
    end else if (fetch_slot) begin
      if (!bus.Stall) begin
        addr_fault <= bus.FetchEn && addr_oob;
      end
    end else begin
      addr_fault <= 1'b0;
    end
  end

  assign bus.AddrFault = addr_fault;
`else
  assign bus.AddrFault = 1'b0;
`endif

  assign bus.Instruction = instr;
  assign bus.InstValid   = inst_valid;
  assign bus.LoadReady   = (state == LOAD);
  assign bus.Busy        = (state == LOAD);

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Scoreboard bench for instruction_memory_sync: directed scenarios followed by
// random load/fetch traffic, checked every cycle against a behavioural model.
module tb_instruction_memory_sync;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;

  instruction_memory_sync_if #(.DATA_WIDTH(DW)) bus ();

  instruction_memory_sync #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] instr;
    logic          valid;
    logic          fault;
    logic          ready;
    logic          busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Behavioural model: program image plus a "loading"/"running" view.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_ptr     = 0;
  bit            m_loading = 0;
  bit            m_running = 0;
  logic [DW-1:0] m_instr   = '0;
  bit            m_valid   = 0;
  bit            m_fault   = 0;

  function automatic bit out_of_range(logic [31:0] a);
`ifdef IMEM_BOUNDS_CHECK_EN
    return (a >> (AW + 2)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_step();
    int idx;
    if (reset) begin
      m_loading = 0; m_running = 0; m_ptr = 0;
      m_instr = '0; m_valid = 0; m_fault = 0;
    end else if (m_loading) begin
      if (bus.LoadStart) begin
        m_ptr = 0;
      end else if (bus.LoadValid) begin
        m_mem[m_ptr] = bus.LoadData;
        if (bus.LoadLast || m_ptr == DEPTH - 1) begin
          m_loading = 0;
          m_running = 1;
        end
        m_ptr = m_ptr + 1;
      end
    end else if (m_running) begin
      if (bus.LoadStart) begin
        m_running = 0; m_loading = 1; m_ptr = 0;
        m_instr = '0; m_valid = 0; m_fault = 0;
      end else if (!bus.Stall) begin
        if (bus.FetchEn) begin
          idx     = int'(bus.Address / 4) % DEPTH;
          m_fault = out_of_range(bus.Address);
          m_instr = m_fault ? '0 : m_mem[idx];
          m_valid = 1;
        end else begin
          m_instr = '0; m_valid = 0; m_fault = 0;
        end
      end
    end else if (bus.LoadStart) begin
      m_loading = 1;
      m_ptr     = 0;
    end
  endfunction

  function automatic exp_t model_view();
    exp_t e;
    e.instr = m_instr;
    e.valid = m_valid;
    e.fault = m_fault;
    e.ready = m_loading;
    e.busy  = m_loading;
    return e;
  endfunction

  // One clock: inputs were set by the caller; model follows the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    exp_q.push_back(model_view());
    #1;
  endtask

  task automatic drive(input logic ls, input logic lv, input logic [DW-1:0] ld,
                       input logic ll, input logic fe, input logic st,
                       input logic [31:0] a);
    bus.LoadStart = ls;
    bus.LoadValid = lv;
    bus.LoadData  = ld;
    bus.LoadLast  = ll;
    bus.FetchEn   = fe;
    bus.Stall     = st;
    bus.Address   = a;
    cycle();
  endtask

  // Asynchronous reset between edges: outputs must clear without a clock.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    exp_q.delete();
    model_step();
    exp_q.push_back(model_view());
    #1;
    n_cmp++;
    if (bus.Instruction !== '0 || bus.InstValid !== 1'b0 || bus.AddrFault !== 1'b0 ||
        bus.LoadReady !== 1'b0 || bus.Busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: instr=%h valid=%b fault=%b ready=%b busy=%b, required all zero",
               tag, bus.Instruction, bus.InstValid, bus.AddrFault, bus.LoadReady, bus.Busy);
    end else begin
      $display("reset %s: outputs cleared asynchronously", tag);
    end
  endtask

  // Monitor: every cycle the DUT presents its registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.Instruction !== e.instr || bus.InstValid !== e.valid ||
            bus.AddrFault !== e.fault || bus.LoadReady !== e.ready || bus.Busy !== e.busy) begin
          n_bad++;
          $display("FAIL cycle@%0t: got instr=%h valid=%b fault=%b ready=%b busy=%b, required instr=%h valid=%b fault=%b ready=%b busy=%b",
                   $time, bus.Instruction, bus.InstValid, bus.AddrFault, bus.LoadReady, bus.Busy,
                   e.instr, e.valid, e.fault, e.ready, e.busy);
        end else if (e.valid) begin
          $display("fetch @%0t: instr=%h fault=%b", $time, e.instr, e.fault);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] prog [4];
  logic [DW-1:0] w;
  logic [31:0]   a;

  initial begin
    prog[0] = 32'h241a0001; prog[1] = 32'h8c080000;
    prog[2] = 32'h20040004; prog[3] = 32'h00082821;

    reset = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h0);
    reset = 1'b0;

    // Fetches before any load are ignored.
    drive(0, 0, '0, 0, 1, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h4);

    // Load the 4-word program, LoadLast on the fourth word.
    drive(1, 0, '0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) drive(0, 1, prog[i], logic'(i == 3), 0, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h8);

    // Stall holds the word fetched from 0x0, release fetches 0x4.
    drive(0, 0, '0, 0, 1, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 1, 32'h4);
    drive(0, 0, '0, 0, 0, 1, 32'h4);
    drive(0, 0, '0, 0, 1, 0, 32'h4);
    drive(0, 0, '0, 0, 0, 0, 32'h0);

    // Restarted load with gaps; the word offered alongside LoadStart is dropped.
    drive(1, 0, '0, 0, 1, 0, 32'h0);
    drive(0, 1, 32'haaaa0000, 0, 0, 0, 32'h0);
    drive(0, 0, '0, 0, 0, 0, 32'h0);
    drive(0, 1, 32'hbbbb0001, 0, 0, 0, 32'h0);
    drive(1, 1, 32'hdead0002, 0, 0, 0, 32'h0);
    drive(0, 1, 32'hcccc0003, 0, 0, 0, 32'h0);
    drive(0, 0, '0, 0, 0, 0, 32'h0);
    drive(0, 1, 32'hdddd0004, 1, 0, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h4);
    drive(0, 0, '0, 0, 1, 0, 32'h8);

    // Fill the whole array without LoadLast; the extra word is not taken.
    drive(1, 0, '0, 0, 0, 0, 32'h0);
    for (int i = 0; i <= DEPTH; i++) begin
      w = $urandom;
      drive(0, 1, w, 0, 0, 0, 32'h0);
    end
    drive(0, 0, '0, 0, 1, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h3fc);
    drive(0, 0, '0, 0, 1, 0, 32'h400);
    drive(0, 0, '0, 0, 1, 1, 32'h4);
    drive(0, 0, '0, 0, 1, 0, 32'h404);
    drive(0, 0, '0, 0, 1, 0, 32'h8);

    // Reset during a load.
    drive(1, 0, '0, 0, 0, 0, 32'h0);
    drive(0, 1, 32'h11110000, 0, 0, 0, 32'h0);
    drive(0, 1, 32'h11110001, 0, 1, 0, 32'h0);
    do_reset("mid_load");
    drive(0, 1, 32'h11110002, 0, 1, 0, 32'h0);
    reset = 1'b0;
    drive(0, 0, '0, 0, 1, 0, 32'h0);
    drive(0, 1, 32'h22220000, 1, 1, 0, 32'h4);

    // Reset during RUN fetches.
    drive(1, 0, '0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) drive(0, 1, prog[i], logic'(i == 2), 0, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h4);
    do_reset("mid_run");
    drive(0, 0, '0, 0, 1, 0, 32'h8);
    reset = 1'b0;
    drive(0, 0, '0, 0, 1, 0, 32'h0);
    drive(0, 0, '0, 0, 1, 0, 32'h4);

    // Random traffic starting from a fresh load.
    drive(1, 0, '0, 0, 0, 0, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      if ($urandom_range(7) != 0) a[31:AW+2] = '0;
      drive(logic'($urandom_range(49) == 0), logic'($urandom_range(9) < 7), $urandom,
            logic'($urandom_range(19) == 0), logic'($urandom_range(9) < 7),
            logic'($urandom_range(3) == 0), a);
    end

    drive(0, 0, '0, 0, 0, 0, 32'h0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_memory_sync.md
# instruction_memory_sync

Parametrised, loadable instruction memory for the pipelined CPU, replacing the fixed combinational instruction ROM. It holds 2^ADDR_WIDTH words, is filled at run time through a streaming load port with a valid/ready handshake, and serves the IF stage through a registered read with one-cycle latency and stall hold. A small state machine (IDLE/LOAD/RUN) sequences loading and fetching.

## Interface
- ADDR_WIDTH, 8: word-index bits; depth DEPTH = 2^ADDR_WIDTH words.
- DATA_WIDTH, 32: instruction width.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- FetchEn  input  1  IF stage requests a fetch this cycle.
- Stall  input  1  hold current output (pipeline stall).
- Address  input  32  byte address from PC; word index = Address[ADDR_WIDTH+1:2]; Address[1:0] ignored.
- Instruction  output  DATA_WIDTH  registered instruction.
- InstValid  output  1  Instruction holds a valid fetch result.
- AddrFault  output  1  registered out-of-range flag (see Configuration).
- LoadStart  input  1  begin (or restart) program load at word 0.
- LoadValid  input  1  LoadData valid.
- LoadData  input  DATA_WIDTH  word to write.
- LoadLast  input  1  qualifies the final load word.
- LoadReady  output  1  load port accepts a word.
- Busy  output  1  high while in LOAD.

## Operation
- States: IDLE, LOAD, RUN. Reset enters IDLE.
- IDLE: LoadReady=0, Busy=0, fetches ignored. LoadStart -> LOAD, load pointer := 0.
- LOAD: LoadReady=1, Busy=1. Each cycle with LoadValid&LoadReady writes LoadData to mem[pointer], pointer += 1.
- LOAD exit: accepted word with LoadLast=1 -> RUN; accepted write at pointer = DEPTH-1 -> RUN regardless of LoadLast (no wrap, no overwrite of word 0).
- LoadStart in LOAD: pointer := 0, any LoadValid word that cycle is dropped (LoadStart wins).
- LoadStart in RUN: -> LOAD, pointer := 0, InstValid := 0, Instruction := 0 (pipeline sees NOP).
- RUN: FetchEn=1, Stall=0 -> Instruction := mem[word index], InstValid := 1. FetchEn=0, Stall=0 -> Instruction := 0, InstValid := 0. Stall=1 -> Instruction, InstValid, AddrFault hold (Stall has priority over FetchEn).
- Outside RUN, Instruction=0, InstValid=0, AddrFault=0.
- Memory array not cleared by reset; contents survive reset but RUN is reachable only via a load.
- Load and fetch are mutually exclusive by state; no read-during-write case exists.

## Timing
- Reset values: Instruction=0, InstValid=0, AddrFault=0, LoadReady=0, Busy=0, pointer=0, state IDLE.
- Fetch latency: Address sampled at edge N, Instruction/InstValid valid after edge N, usable in cycle N+1.
- LoadReady and Busy are registered state decodes: LoadReady rises the cycle after LoadStart is sampled.
- Last accepted load word at edge N: state RUN from edge N, first fetch sampled at edge N+1 sees the new word.
- Reset asserted mid-load or mid-fetch: immediate return to IDLE, outputs to reset values; partially loaded words remain in array.

## Configuration
- IMEM_BOUNDS_CHECK_EN defined: in RUN fetch with Address[31:ADDR_WIDTH+2] != 0 yields Instruction := 0, InstValid := 1, AddrFault := 1 (same latency as a normal fetch); in-range fetch clears AddrFault.
- Not defined: upper address bits ignored (index wraps modulo DEPTH); AddrFault tied 0.

## Test plan
- Reset, LoadStart, stream 4 words 32'h241a0001, 32'h8c080000, 32'h20040004, 32'h00082821 with LoadLast on 4th -> Busy falls, fetch Address=32'h8 returns 32'h20040004 with InstValid=1 one cycle later.
- Fetch 0x0, 0x4 with Stall=1 on second cycle -> Instruction holds 32'h241a0001 while Stall high, then 32'h8c080000 after release.
- Load with LoadValid gaps and LoadStart asserted after 2 words -> pointer restarts; word 0 equals first word of restarted stream.
- ADDR_WIDTH=2, stream 5 words without LoadLast -> RUN entered after 4th write, LoadReady=0, 5th word not written, word 0 unchanged.
- Address=32'h400 (ADDR_WIDTH=8): with IMEM_BOUNDS_CHECK_EN -> Instruction=0, AddrFault=1; without -> returns mem[0], AddrFault=0.
- Reset asserted during LOAD and during RUN fetch -> outputs zero asynchronously, state IDLE, FetchEn ignored until next completed load.
